// File: rtl/huff_decoder_atom.sv
// Huffman decoder atom: per-symbol LUT (codeword, length) loaded through the
// config port, MSB-first bit buffer fed by IN_WIDTH-bit beats, and one decoded
// symbol per cycle on a valid/ready output. A buffer whose oldest bits cannot
// start any codeword raises a sticky error that only flush, config or reset clear.
module huff_decoder_atom #(
  parameter int SYMBOL_WIDTH      = 4,
  parameter int ENC_MAX_WIDTH     = 4,
  parameter int ENC_MAX_LEN_WIDTH = 3,
  parameter int NUM_SYMBOLS       = 16,
  parameter int IN_WIDTH          = 4,
  parameter int BUF_DEPTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         config_en,
  input  logic [SYMBOL_WIDTH-1:0]      config_select,
  input  logic [ENC_MAX_WIDTH-1:0]     config_enc,
  input  logic [ENC_MAX_LEN_WIDTH-1:0] config_enc_len,
  input  logic                         flush,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [SYMBOL_WIDTH-1:0]      out_symbol,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] C_IN   = CW'(IN_WIDTH);
  localparam logic [CW-1:0] C_BUF  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] C_EW   = CW'(ENC_MAX_WIDTH);
  localparam logic [ENC_MAX_LEN_WIDTH-1:0] C_EW_LEN = ENC_MAX_LEN_WIDTH'(ENC_MAX_WIDTH);

  logic [ENC_MAX_WIDTH-1:0]     r_code [NUM_SYMBOLS];
  logic [ENC_MAX_LEN_WIDTH-1:0] r_len  [NUM_SYMBOLS];
  logic [BUF_DEPTH-1:0]         r_buf;
  logic [CW-1:0]                r_count;
  logic [SYMBOL_WIDTH-1:0]      r_symbol;
  logic                         r_valid;
  logic                         r_err;

  logic [NUM_SYMBOLS-1:0]       w_hit;
  logic                         w_match;
  logic [SYMBOL_WIDTH-1:0]      w_idx;
  logic [ENC_MAX_LEN_WIDTH-1:0] w_len;
  logic                         w_run_ok;
  logic                         w_fire;
  logic                         w_accept;
  logic                         w_err_set;
  logic [CW-1:0]                w_rem;
  logic [CW-1:0]                w_count_next;
  logic [BUF_DEPTH-1:0]         w_shifted;
  logic [BUF_DEPTH-1:0]         w_ins;
  logic [BUF_DEPTH-1:0]         w_buf_next;

  // Per-entry match: compare the top len bits of the buffer with the left-aligned codeword.
  always_comb begin
    logic [ENC_MAX_LEN_WIDTH-1:0] v_shift;
    logic [ENC_MAX_WIDTH-1:0]     v_mask;
    logic [ENC_MAX_WIDTH-1:0]     v_aligned;
    w_hit     = '0;
    v_shift   = '0;
    v_mask    = '0;
    v_aligned = '0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      v_shift   = C_EW_LEN - r_len[i];
      v_mask    = {ENC_MAX_WIDTH{1'b1}} << v_shift;
      v_aligned = r_code[i] << v_shift;
      w_hit[i]  = (r_len[i] != '0) && (CW'(r_len[i]) <= r_count) &&
                  (((r_buf[BUF_DEPTH-1 -: ENC_MAX_WIDTH] ^ v_aligned) & v_mask) == '0);
    end
  end

  // Priority select: scanning downward leaves the lowest matching index in place.
  always_comb begin
    w_match = 1'b0;
    w_idx   = '0;
    w_len   = '0;
    for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_match = 1'b1;
        w_idx   = SYMBOL_WIDTH'(i);
        w_len   = r_len[i];
      end else begin
        w_match = w_match;
      end
    end
  end

  // Handshakes and next buffer state; incoming bits land below the post-decode remainder.
  always_comb begin
    w_run_ok     = !config_en && !flush && !r_err;
    in_ready     = rst_n && w_run_ok && (r_count <= (C_BUF - C_IN));
    w_fire       = w_match && w_run_ok && (!r_valid || out_ready);
    w_accept     = in_valid && in_ready;
    w_err_set    = (r_count >= C_EW) && !w_match;
    w_rem        = w_fire ? (r_count - CW'(w_len)) : r_count;
    w_shifted    = w_fire ? (r_buf << w_len) : r_buf;
    w_ins        = {in_data, {(BUF_DEPTH - IN_WIDTH){1'b0}}} >> w_rem;
    w_buf_next   = w_accept ? (w_shifted | w_ins) : w_shifted;
    w_count_next = w_accept ? (w_rem + C_IN) : w_rem;
  end

  // LUT storage: cleared on reset, one entry written per config strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) begin
        r_code[i] <= '0;
        r_len[i]  <= '0;
      end
    end else if (config_en) begin
      r_code[config_select] <= config_enc;
      r_len[config_select]  <= config_enc_len;
    end
  end

  // Bit buffer, fill count and sticky error; config and flush both empty the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (config_en || flush) begin
      r_buf   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output register: load on decode, drop valid once the sink has taken the symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_symbol <= '0;
      r_valid  <= 1'b0;
    end else if (w_fire) begin
      r_symbol <= w_idx;
      r_valid  <= 1'b1;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_symbol = r_symbol;
  assign out_valid  = r_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_huff_decoder_atom.sv
// Scoreboard bench for huff_decoder_atom: stimulus pushes expected symbols from a
// bit-queue prefix-decoding model; a negedge monitor pops on every output handshake.
module tb_huff_decoder_atom;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       config_en = 1'b0;
  logic [3:0] config_select = 4'd0;
  logic [3:0] config_enc = 4'd0;
  logic [2:0] config_enc_len = 3'd0;
  logic       flush = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_symbol;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;

  int checks = 0;
  int failures = 0;
  int sbq[$];
  bit mq[$];
  int m_code[16];
  int m_len[16];
  bit ready_mode = 1'b0;
  bit ready_cmd = 1'b1;

  huff_decoder_atom dut (
    .clk(clk), .rst_n(rst_n), .config_en(config_en), .config_select(config_select),
    .config_enc(config_enc), .config_enc_len(config_enc_len), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_symbol(out_symbol), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: greedily strip the lowest-index codeword prefixing the bit queue.
  function automatic void model_run();
    bit progress;
    bit ok;
    progress = 1'b1;
    while (progress) begin
      progress = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (m_len[i] > 0 && m_len[i] <= mq.size()) begin
          ok = 1'b1;
          for (int k = 0; k < m_len[i]; k++)
            if (mq[k] != m_code[i][m_len[i]-1-k]) ok = 1'b0;
          if (ok) begin
            sbq.push_back(i);
            for (int k = 0; k < m_len[i]; k++) void'(mq.pop_front());
            progress = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_push(input logic [3:0] beat);
    for (int k = 3; k >= 0; k--) mq.push_back(beat[k]);
    model_run();
  endfunction

  // Sink ready: scripted or random, always driven away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = ready_cmd;
  end

  // Output monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_symbol: got %0d, expected none", out_symbol);
      end else begin
        check("symbol", int'(out_symbol), sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] d, input bit use_model);
    bit accepted;
    accepted = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("beat_accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    if (accepted && use_model) model_push(d);
  endtask

  task automatic cfg(input int sel, input logic [3:0] code, input logic [2:0] len);
    config_en      = 1'b1;
    config_select  = 4'(sel);
    config_enc     = code;
    config_enc_len = len;
    @(negedge clk);
    check("cfg_in_ready", int'(in_ready), 0);
    tick();
    config_en  = 1'b0;
    m_code[sel] = int'(code);
    m_len[sel]  = int'(len);
    mq.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    mq.delete();
    @(negedge clk);
    check("flush_err", int'(err), 0);
    check("flush_ready_back", int'(in_ready), 1);
    tick();
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    check("drain_empty", sbq.size(), 0);
    repeat (3) tick();
  endtask

  task automatic load_table();
    cfg(0, 4'b0000, 3'd1);
    cfg(1, 4'b0010, 3'd2);
    cfg(2, 4'b0110, 3'd3);
    cfg(3, 4'b0111, 3'd3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_code[i] = 0;
      m_len[i]  = 0;
    end
    // 1: reset state, then release
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    tick();
    load_table();
    repeat (4) tick();

    // 2: single beat, first symbol one edge after accept
    send_beat(4'b0100, 1'b1);
    tick();
    check("latency_valid", int'(out_valid), 1);
    check("latency_symbol", int'(out_symbol), 0);
    drain(20);

    // 3: codeword straddling a beat boundary
    send_beat(4'b1101, 1'b1);
    send_beat(4'b1100, 1'b1);
    drain(20);

    // 4: sink stall holds output and back-pressures a full buffer
    ready_cmd = 1'b0;
    send_beat(4'b0100, 1'b1);
    send_beat(4'b0100, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_symbol", int'(out_symbol), 0);
      check("stall_in_ready", int'(in_ready), 0);
      tick();
    end
    ready_cmd = 1'b1;
    drain(40);

    // 5: unmatched bits raise a sticky error until flush
    cfg(3, 4'b0000, 3'd0);
    send_beat(4'b1111, 1'b1);
    tick();
    check("err_set", int'(err), 1);
    check("err_in_ready", int'(in_ready), 0);
    repeat (2) tick();
    check("err_sticky", int'(err), 1);
    do_flush();
    cfg(3, 4'b0111, 3'd3);

    // 6: config pulse drops buffered bits but holds the pending output
    ready_cmd = 1'b0;
    send_beat(4'b0110, 1'b0);
    sbq.push_back(0);
    repeat (2) tick();
    cfg(0, 4'b0000, 3'd1);
    check("cfg_hold_valid", int'(out_valid), 1);
    check("cfg_hold_symbol", int'(out_symbol), 0);
    ready_cmd = 1'b1;
    drain(20);
    send_beat(4'b1000, 1'b1);
    drain(20);

    // Async reset mid-stream clears outputs and the LUT
    send_beat(4'b0000, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_in_ready", int'(in_ready), 0);
    sbq.delete();
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      m_code[i] = 0;
      m_len[i]  = 0;
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_beat(4'b0000, 1'b1);
    tick();
    check("lut_cleared_err", int'(err), 1);
    do_flush();
    load_table();

    // Randomized stream with random sink back-pressure
    ready_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send_beat(4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 4) == 0) tick();
    end
    drain(400);
    check("rand_no_err", int'(err), 0);
    ready_mode = 1'b0;
    do_flush();
    repeat (4) tick();
    check("final_queue_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
